// File: rtl/lcd_spi_arbiter.sv
// rtl/lcd_spi_arbiter.sv - round-robin packet arbiter for the shared PCD8544 SPI byte channel (optional LCD_SPI_ARB_TIMEOUT_EN)
module lcd_spi_arbiter #(
  parameter int N       = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_dc,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic           spi_start,
  output logic [7:0]     spi_data,
  output logic           spi_dc,
  input  logic           spi_done,
  output logic           arb_busy,
  output logic           timeout_flag
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("lcd_spi_arbiter: N must be 2..8 and TIMEOUT at least 1");
  end

  state_t        state_q, state_d;
  logic [N-1:0]  grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx, pick;
  logic          pick_ok;
  logic [7:0]    data_d;
  logic          dc_d, last_q, last_d, start_d;
  int            cand;

`ifdef LCD_SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tflag_d;
`endif

  assign arb_busy = |grant;

  // Encode the one-hot grant into the index of the owning lane
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) gidx = IW'(i);
    end
  end

  // Round-robin search: first requesting lane above the pointer, wrapping
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!pick_ok && req_valid[cand]) begin
        pick    = IW'(cand);
        pick_ok = 1'b1;
      end
    end
  end

  // Next-state and output decode; packet ownership only changes on a last byte or timeout
  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    ptr_d     = ptr_q;
    data_d    = spi_data;
    dc_d      = spi_dc;
    last_d    = last_q;
    start_d   = 1'b0;
    req_ready = '0;
`ifdef LCD_SPI_ARB_TIMEOUT_EN
    cnt_d     = '0;
    tflag_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        req_ready = grant;
        if (req_valid[gidx]) begin
          data_d  = req_data[8*gidx +: 8];
          dc_d    = req_dc[gidx];
          last_d  = req_last[gidx];
          start_d = 1'b1;
          state_d = SEND;
        end
`ifdef LCD_SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          grant_d = '0;
          ptr_d   = gidx;
          tflag_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (spi_done) begin
          if (last_q) begin
            ptr_d   = gidx;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, pointer and the byte presented to spi_master
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant     <= '0;
      ptr_q     <= IW'(N - 1);
      spi_data  <= 8'h00;
      spi_dc    <= 1'b0;
      last_q    <= 1'b0;
      spi_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      ptr_q     <= ptr_d;
      spi_data  <= data_d;
      spi_dc    <= dc_d;
      last_q    <= last_d;
      spi_start <= start_d;
    end
  end

`ifdef LCD_SPI_ARB_TIMEOUT_EN
  // Idle-hold counter and the forced-release pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      timeout_flag <= tflag_d;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// tb/tb_lcd_spi_arbiter.sv - directed self-checking bench for lcd_spi_arbiter
module tb_lcd_spi_arbiter;
  localparam int N = 3;
`ifdef LCD_SPI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_dc;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           spi_start;
  logic [7:0]     spi_data;
  logic           spi_dc;
  logic           spi_done;
  logic           arb_busy;
  logic           timeout_flag;

  always #5 clk = ~clk;

  lcd_spi_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_dc(req_dc), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .spi_start(spi_start), .spi_data(spi_data), .spi_dc(spi_dc), .spi_done(spi_done),
    .arb_busy(arb_busy), .timeout_flag(timeout_flag)
  );

  int total = 0;
  int bad = 0;

  // per-lane packet bytes {last, dc, data}; wr owned by main, rd by driver
  logic [9:0] pk [N][64];
  int         wr [N];
  int         rd [N];
  logic [N-1:0] hs;

  logic [7:0]   log_data  [64];
  logic         log_dc    [64];
  logic [N-1:0] log_grant [64];
  int           log_n;

  logic auto_done, auto_pulse, man_done;
  assign spi_done = auto_pulse | man_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int lane, input logic [9:0] v);
    pk[lane][wr[lane]] = v;
    wr[lane] = wr[lane] + 1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_n < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_log", 32'(log_n >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (grant != '0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_idle", 32'(grant), 32'd0);
  endtask

  // requester lanes: present queued bytes, advance on handshake
  initial begin
    rd = '{default: 0};
    hs = '0;
    req_valid = '0; req_data = '0; req_dc = '0; req_last = '0;
    forever begin
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && rd[i] < wr[i]) rd[i] = rd[i] + 1;
        if (rd[i] < wr[i]) begin
          req_valid[i] = 1'b1;
          {req_last[i], req_dc[i], req_data[8*i +: 8]} = pk[i][rd[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      hs = req_valid & req_ready;
    end
  end

  // spi_master stand-in: done 8 cycles after each start
  initial begin
    auto_pulse = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (auto_done && spi_start) begin
        repeat (8) @(negedge clk);
        #1 auto_pulse = 1'b1;
        @(negedge clk);
        #1 auto_pulse = 1'b0;
      end
    end
  end

  // record every byte started on the channel
  initial begin
    log_n = 0;
    forever begin
      @(negedge clk); #2;
      if (spi_start) begin
        log_data[log_n]  = spi_data;
        log_dc[log_n]    = spi_dc;
        log_grant[log_n] = grant;
        log_n++;
      end
    end
  end

  initial begin
    int base, k;
    logic leak;
    logic [7:0]   exp_d [8];
    logic [N-1:0] exp_g [8];
    reset = 1'b0; auto_done = 1'b0; man_done = 1'b0;
    wr = '{default: 0};
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_data", 32'(spi_data), 0);
    chk("rst_dc", 32'(spi_dc), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_tflag", 32'(timeout_flag), 0);
    reset = 1'b1;

    // lane 0 three-byte command packet
    @(negedge clk);
    auto_done = 1'b1;
    base = log_n;
    push(0, {2'b00, 8'h21}); push(0, {2'b00, 8'h90}); push(0, {2'b10, 8'h0C});
    wait_log(base + 3, 200);
    exp_d = '{8'h21, 8'h90, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      chk("t1_data", 32'(log_data[base+i]), 32'(exp_d[i]));
      chk("t1_dc", 32'(log_dc[base+i]), 0);
      chk("t1_grant", 32'(log_grant[base+i]), 32'h1);
    end
    wait_idle(50);
    chk("t1_busy", 32'(arb_busy), 0);

    // single-byte data packet on lane 1, exact latency
    auto_done = 1'b0;
    @(negedge clk);
    push(1, {2'b11, 8'hAA});
    @(negedge clk);
    chk("t5_grant", 32'(grant), 32'h2);
    chk("t5_ready", 32'(req_ready), 32'h2);
    chk("t5_nostart", 32'(spi_start), 0);
    @(negedge clk);
    chk("t5_start", 32'(spi_start), 1);
    chk("t5_data", 32'(spi_data), 32'hAA);
    chk("t5_dc", 32'(spi_dc), 1);
    chk("t5_ready_send", 32'(req_ready), 0);
    repeat (3) @(negedge clk);
    chk("t5_hold_grant", 32'(grant), 32'h2);
    chk("t5_start_once", 32'(spi_start), 0);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("t5_release", 32'(grant), 0);
    chk("t5_busy", 32'(arb_busy), 0);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    @(negedge clk);
    chk("t5_done_idle_start", 32'(spi_start), 0);
    chk("t5_done_idle_grant", 32'(grant), 0);

    // lanes 0 and 1 each stream two 2-byte packets
    auto_done = 1'b1;
    base = log_n;
    push(0, {2'b00, 8'hA0}); push(0, {2'b10, 8'hA1}); push(0, {2'b00, 8'hA2}); push(0, {2'b10, 8'hA3});
    push(1, {2'b01, 8'hB0}); push(1, {2'b11, 8'hB1}); push(1, {2'b01, 8'hB2}); push(1, {2'b11, 8'hB3});
    wait_log(base + 8, 600);
    exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
    exp_g = '{3'h1, 3'h1, 3'h2, 3'h2, 3'h1, 3'h1, 3'h2, 3'h2};
    for (int i = 0; i < 8; i++) begin
      chk("t2_data", 32'(log_data[base+i]), 32'(exp_d[i]));
      chk("t2_grant", 32'(log_grant[base+i]), 32'(exp_g[i]));
    end
    wait_idle(50);

    // lane 2 arrives while lane 0 is mid-packet
    base = log_n;
    push(0, {2'b00, 8'hC0}); push(0, {2'b10, 8'hC1});
    wait_log(base + 1, 100);
    push(2, {2'b10, 8'hD0});
    leak = 1'b0;
    k = 0;
    while (grant[0] && k < 200) begin
      @(negedge clk);
      leak = leak | req_ready[2] | grant[2];
      k++;
    end
    chk("t3_no_leak", 32'(leak), 0);
    wait_log(base + 3, 200);
    chk("t3_c1", 32'(log_data[base+1]), 32'hC1);
    chk("t3_c1_grant", 32'(log_grant[base+1]), 32'h1);
    chk("t3_d0", 32'(log_data[base+2]), 32'hD0);
    chk("t3_d0_grant", 32'(log_grant[base+2]), 32'h4);
    wait_idle(50);

    // reset in SEND, then a stale spi_done
    auto_done = 1'b0;
    base = log_n;
    push(0, {2'b00, 8'hE0}); push(0, {2'b10, 8'hE1});
    wait_log(base + 1, 50);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr[0] = rd[0];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_grant", 32'(grant), 0);
    chk("t4_data", 32'(spi_data), 0);
    chk("t4_dc", 32'(spi_dc), 0);
    chk("t4_start", 32'(spi_start), 0);
    chk("t4_busy", 32'(arb_busy), 0);
    chk("t4_ready", 32'(req_ready), 0);
    chk("t4_no_byte", 32'(log_n), 32'(base + 1));
    auto_done = 1'b1;
    push(1, {2'b10, 8'hF0});
    wait_log(base + 2, 100);
    chk("t4_f0", 32'(log_data[base+1]), 32'hF0);
    chk("t4_f0_grant", 32'(log_grant[base+1]), 32'h2);
    wait_idle(50);

`ifdef LCD_SPI_ARB_TIMEOUT_EN
    // lane 0 stalls mid-packet; forced release hands over to lane 1
    auto_done = 1'b0;
    base = log_n;
    push(0, {2'b00, 8'h11});
    push(1, {2'b10, 8'h22});
    wait_log(base + 1, 50);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    k = 1;
    while (!timeout_flag && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t6_flag", 32'(timeout_flag), 1);
    chk("t6_cycles", 32'(k), 32'd17);
    chk("t6_grant0", 32'(grant), 0);
    @(negedge clk);
    chk("t6_flag_pulse", 32'(timeout_flag), 0);
    chk("t6_next", 32'(grant), 32'h2);
    auto_done = 1'b1;
    wait_log(base + 2, 100);
    chk("t6_byte", 32'(log_data[base+1]), 32'h22);
    wait_idle(50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
